// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter with a small input FIFO.
//   Bytes arrive over a valid/ready handshake, queue in a circular buffer,
//   and are serialised as 1 start bit, 8 data bits (LSB first) and 1 stop bit.
//   Each bit lasts CLKS_PER_BIT cycles. Back-to-back frames have no idle gap.
// Ports:
//   clk, rst_n       clock (rising edge); asynchronous active-low reset
//   tx_data[7:0]     byte to send
//   tx_valid         tx_data is valid; pushed when tx_valid && tx_ready
//   tx_ready         FIFO can accept a byte (combinational from the count)
//   data_out         serial line, idle high (registered)
//   busy             frame in progress or FIFO non-empty (combinational)
//   tx_done          1-cycle pulse at the end of each stop bit (registered)
//   fifo_count       bytes queued, excluding the byte in the shifter
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             data_out,
  output logic             busy,
  output logic             tx_done,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CLK_W = $clog2(CLKS_PER_BIT);
  localparam logic [CLK_W-1:0] BIT_LAST = CLK_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CLK_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             data_out_q, data_out_d;
  logic             stop_end_q, stop_end_d;
  logic             tx_done_q;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic push, pop, bit_end, fifo_nonempty;

  assign tx_ready      = (count_q < CNT_W'(FIFO_DEPTH));
  assign push          = tx_valid && tx_ready;
  assign fifo_nonempty = (count_q != '0);
  assign bit_end       = (clk_cnt_q == BIT_LAST);

  // Line value is registered from the current state, so the line lags the
  // FSM by one cycle: pop at edge N+1, start bit appears at edge N+2.
  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_out_d = 1'b1;
    stop_end_d = 1'b0;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        data_out_d = 1'b1;
        if (fifo_nonempty) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        data_out_d = 1'b0;
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        data_out_d = shift_q[0];
        if (bit_end) begin
          clk_cnt_d = '0;
          shift_d   = shift_q >> 1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        data_out_d = 1'b1;
        if (bit_end) begin
          stop_end_d = 1'b1;
          clk_cnt_d  = '0;
          if (fifo_nonempty) begin
            pop       = 1'b1;
            shift_d   = mem_q[rd_ptr_q];
            bit_cnt_d = '0;
            state_d   = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        data_out_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_out_q <= 1'b1;
      stop_end_q <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_out_q <= data_out_d;
      // Extra stage keeps tx_done aligned with the end of the stop bit as
      // seen on the line, which itself lags the FSM by one cycle.
      stop_end_q <= stop_end_d;
      tx_done_q  <= stop_end_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  assign data_out   = data_out_q;
  assign tx_done    = tx_done_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != S_IDLE) || fifo_nonempty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized self-checking bench for uart_tx_fifo.
//   A frame-level reference model (byte queue + phase within a 10-bit frame)
//   predicts every output each cycle; a loopback decoder recovers bytes from
//   the line and compares them to the bytes the model says were accepted.
module tb_uart_tx_fifo;

  localparam int C = 16;
  localparam int D = 4;
  localparam int FRAME = 10 * C;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       data_out;
  logic       busy;
  logic       tx_done;
  logic [2:0] fifo_count;

  uart_tx_fifo #(
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (D),
    .CNT_W       (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .data_out  (data_out),
    .busy      (busy),
    .tx_done   (tx_done),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: queue of waiting bytes and position within current frame.
  logic [7:0] mq[$];
  bit         m_active;
  int         m_phase;
  logic [7:0] m_byte;
  bit         m_end_prev;
  logic       m_line;
  logic       m_done;
  bit         m_acc;
  logic [7:0] sent_q[$];

  // Loopback decoder.
  logic [7:0] rx_q[$];
  bit         rx_act;
  int         rx_cnt;
  logic       rx_prev;
  logic [7:0] rx_sh;

  int cyc = 0;
  int fall_cyc = -1;
  int done_cyc = -1;
  int done_seen = 0;

  logic [7:0] to_send[$];

  function automatic logic frame_bit(input int phase, input logic [7:0] b);
    int k;
    k = phase / C;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  function automatic bit pop_next();
    return (mq.size() != 0) && (!m_active || m_phase == FRAME - 1);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_active = 0; m_phase = 0; m_byte = '0;
    m_end_prev = 0; m_line = 1'b1; m_done = 1'b0; m_acc = 0;
  endtask

  task automatic model_step();
    bit end_now, pop;
    end_now = m_active && (m_phase == FRAME - 1);
    pop     = pop_next();
    m_acc   = tx_valid && (mq.size() < D);
    m_done  = m_end_prev;
    m_end_prev = end_now;
    m_line  = m_active ? frame_bit(m_phase, m_byte) : 1'b1;
    if (end_now) m_active = 0;
    else if (m_active) m_phase++;
    if (pop) begin
      m_byte = mq.pop_front();
      m_active = 1;
      m_phase = 0;
    end
    if (m_acc) begin
      mq.push_back(tx_data);
      sent_q.push_back(tx_data);
    end
  endtask

  task automatic rx_reset();
    rx_act = 0; rx_cnt = 0; rx_prev = 1'b1; rx_sh = '0;
  endtask

  task automatic rx_sample();
    int k;
    if (!rx_act) begin
      if (rx_prev && !data_out) begin
        rx_act = 1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % C == C / 2) begin
        k = rx_cnt / C;
        if (k >= 1 && k <= 8) rx_sh[k-1] = data_out;
        if (k == 9) begin
          rx_q.push_back(rx_sh);
          rx_act = 0;
        end
      end
    end
    rx_prev = data_out;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    @(negedge clk);
    cyc++;
    chk("data_out",   {31'd0, data_out}, {31'd0, m_line});
    chk("tx_done",    {31'd0, tx_done},  {31'd0, m_done});
    chk("busy",       {31'd0, busy},     {31'd0, (m_active || mq.size() != 0)});
    chk("fifo_count", {29'd0, fifo_count}, 32'(mq.size()));
    chk("tx_ready",   {31'd0, tx_ready}, {31'd0, (mq.size() < D)});
    if (rx_prev && !data_out && fall_cyc < 0) fall_cyc = cyc;
    if (tx_done === 1'b1) begin
      done_seen++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    rx_sample();
  endtask

  task automatic send_all();
    int budget;
    budget = 0;
    while (to_send.size() != 0 && budget < 5000) begin
      tx_valid = 1'b1;
      tx_data  = to_send[0];
      tick();
      if (m_acc) void'(to_send.pop_front());
      budget++;
    end
    tx_valid = 1'b0;
    chk("send_budget", 32'(to_send.size()), 32'd0);
  endtask

  task automatic drain_and_compare(input string tag);
    int budget;
    budget = 0;
    tx_valid = 1'b0;
    while ((m_active || mq.size() != 0 || m_end_prev || m_done) && budget < 5000) begin
      tick();
      budget++;
    end
    repeat (4) tick();
    chk({tag, "_drain"}, {31'd0, (budget < 5000)}, 32'd1);
    chk({tag, "_rx_n"}, 32'(rx_q.size()), 32'(sent_q.size()));
    for (int i = 0; i < rx_q.size() && i < sent_q.size(); i++)
      chk({tag, "_rx_byte"}, {24'd0, rx_q[i]}, {24'd0, sent_q[i]});
    rx_q.delete();
    sent_q.delete();
  endtask

  initial begin
    int budget;
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0;
    model_reset();
    rx_reset();
    repeat (3) tick();
    rst_n = 1'b1;

    // Long idle: line high, never busy, no tx_done.
    done_seen = 0;
    repeat (1000) tick();
    chk("idle_done_cnt", 32'(done_seen), 32'd0);

    // Single byte 0xA5: tx_done 160 clks after the start-bit falling edge.
    fall_cyc = -1; done_cyc = -1; done_seen = 0;
    to_send.push_back(8'hA5);
    send_all();
    drain_and_compare("a5");
    chk("a5_done_cnt", 32'(done_seen), 32'd1);
    chk("a5_done_lat", 32'(done_cyc - fall_cyc), 32'd160);

    // Three bytes on consecutive cycles.
    to_send.push_back(8'h00);
    to_send.push_back(8'hFF);
    to_send.push_back(8'h55);
    send_all();
    drain_and_compare("three");

    // Six bytes with tx_valid held: stalls when full, nothing lost.
    for (int i = 0; i < 6; i++) to_send.push_back(8'($urandom));
    send_all();
    drain_and_compare("six");

    // Keep two queued while pushing exactly when a pop happens.
    for (int n = 0; n < 12; ) begin
      tx_data  = 8'($urandom);
      tx_valid = (mq.size() < 2) || (mq.size() == 2 && pop_next());
      tick();
      if (m_acc) n++;
    end
    drain_and_compare("wrap");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      tx_valid = ($urandom_range(0, 3) == 0);
      tx_data  = 8'($urandom);
      tick();
    end
    drain_and_compare("rand");

    // Reset mid-data-bit with two bytes queued behind the shifting one.
    to_send.push_back(8'h3C);
    to_send.push_back(8'hC3);
    to_send.push_back(8'h81);
    send_all();
    budget = 0;
    while (!(m_active && m_phase >= 4 * C) && budget < 500) begin
      tick();
      budget++;
    end
    chk("rst_reach_data", {31'd0, (budget < 500)}, 32'd1);
    chk("rst_queued", 32'(mq.size()), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("rst_line",  {31'd0, data_out}, 32'd1);
    chk("rst_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_done",  {31'd0, tx_done}, 32'd0);
    model_reset();
    rx_reset();
    rx_q.delete();
    sent_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    done_seen = 0;
    repeat (400) tick();
    chk("post_rst_rx", 32'(rx_q.size()), 32'd0);
    chk("post_rst_done", 32'(done_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
